// File: rtl/elevator_pkg.sv
// Shared elevator types: floor FSM states and one-hot floor helpers.
// Used by the sensor encoder and the display path.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 3;

    typedef enum logic [1:0] {
        UNKNOWN,
        AT_FLOOR,
        BETWEEN,
        FAULT
    } floor_state_t;

    // Binary floor number 1..NUM_FLOORS; 0 when no bit is set.
    function automatic logic [1:0] onehot_to_index(input logic [NUM_FLOORS-1:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (onehot[i]) idx = 2'(i + 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus debounce counter for a vector of landing sensors.
// Emits the held candidate pattern and a registered single-cycle qualify pulse.
module sensor_debounce #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sensor_raw,
    output logic [WIDTH-1:0] candidate,
    output logic             qualify
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            candidate <= '0;
            cnt       <= '0;
            qualify   <= 1'b0;
        end else begin
            s1      <= sensor_raw;
            s2      <= s1;
            qualify <= 1'b0;
            if (s2 != candidate) begin
                candidate <= s2;
                cnt       <= '0;
                // A single sample is already qualified when no extra agreement is required.
                qualify   <= (DEBOUNCE_CYCLES == 1);
            end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt     <= cnt_inc;
                qualify <= (DEBOUNCE_CYCLES > 1) && (cnt_inc == CNT_W'(DEBOUNCE_CYCLES - 1));
            end
        end
    end

endmodule

// File: rtl/floor_sensor_encoder.sv
// Turns noisy landing sensors into clean registered one-hot floor lines,
// with a floor FSM that flags multi-sensor faults and pulses on floor changes.
module floor_sensor_encoder #(
    parameter int unsigned NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] sensor_raw,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic [1:0]            floor_index,
    output logic                  floor_valid,
    output logic                  floor_changed,
    output logic                  multi_err
);

    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] candidate;
    logic                  qualify;
    floor_state_t          state;

    sensor_debounce #(
        .WIDTH          (NUM_FLOORS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sensor_raw(sensor_raw),
        .candidate (candidate),
        .qualify   (qualify)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= UNKNOWN;
            floor_onehot  <= '0;
            floor_index   <= '0;
            floor_valid   <= 1'b0;
            floor_changed <= 1'b0;
            multi_err     <= 1'b0;
        end else begin
            floor_changed <= 1'b0;
            if (qualify) begin
                if ($onehot(candidate)) begin
                    state         <= AT_FLOOR;
                    floor_onehot  <= candidate;
                    floor_index   <= onehot_to_index(candidate);
                    floor_changed <= (candidate != floor_onehot);
                    floor_valid   <= 1'b1;
                    multi_err     <= 1'b0;
                end else if (candidate == '0) begin
                    // Last floor stays on the display while travelling.
                    if (state == AT_FLOOR) begin
                        state       <= BETWEEN;
                        floor_valid <= 1'b0;
                    end
                end else begin
                    state       <= FAULT;
                    floor_valid <= 1'b0;
                    multi_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_floor_sensor_encoder.sv
// Randomized and directed checks of floor_sensor_encoder against a behavioural model.
module tb_floor_sensor_encoder;

    localparam int unsigned NF  = 3;
    localparam int unsigned DEB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] sensor_raw = '0;
    logic [NF-1:0] floor_onehot;
    logic [1:0]    floor_index;
    logic          floor_valid;
    logic          floor_changed;
    logic          multi_err;

    floor_sensor_encoder #(
        .NUM_FLOORS     (NF),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .floor_onehot (floor_onehot),
        .floor_index  (floor_index),
        .floor_valid  (floor_valid),
        .floor_changed(floor_changed),
        .multi_err    (multi_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the debounce sees raw from two edges ago; a pattern
    // qualifies when it has been seen for exactly DEB consecutive edges, and
    // the floor outputs react one edge later. States: 0 unknown, 1 at floor,
    // 2 between, 3 fault.
    logic [NF-1:0] dly[$] = '{3'd0, 3'd0};
    logic [NF-1:0] rv = '0;
    int            rl = 1;
    bit            qpend = 1'b0;
    logic [NF-1:0] qpat = '0;
    logic [NF-1:0] m_onehot = '0;
    int            m_index = 0;
    int            m_state = 0;
    bit            m_changed = 1'b0;

    task automatic apply_qual(input logic [NF-1:0] p);
        if ($countones(p) == 1) begin
            m_changed = (p != m_onehot);
            m_onehot  = p;
            for (int i = 0; i < NF; i++) if (p[i]) m_index = i + 1;
            m_state = 1;
        end else if (p == 0) begin
            if (m_state == 1) m_state = 2;
        end else begin
            m_state = 3;
        end
    endtask

    task automatic model_step();
        logic [NF-1:0] seen;
        if (rst) begin
            dly.delete();
            dly.push_back('0);
            dly.push_back('0);
            rv = '0;
            rl = 1;
            qpend = 1'b0;
            m_onehot = '0;
            m_index = 0;
            m_state = 0;
            m_changed = 1'b0;
        end else begin
            m_changed = 1'b0;
            if (qpend) apply_qual(qpat);
            seen = dly.pop_front();
            dly.push_back(sensor_raw);
            if (seen == rv) rl++;
            else begin
                rv = seen;
                rl = 1;
            end
            qpend = (rl == DEB);
            qpat  = rv;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("floor_onehot", int'(floor_onehot), int'(m_onehot));
            chk("floor_index", int'(floor_index), m_index);
            chk("floor_valid", int'(floor_valid), int'(m_state == 1));
            chk("floor_changed", int'(floor_changed), int'(m_changed));
            chk("multi_err", int'(multi_err), int'(m_state == 3));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input int oh, input int idx, input int vld,
                              input int chg, input int err);
        chk({tag, ".onehot"}, int'(floor_onehot), oh);
        chk({tag, ".index"}, int'(floor_index), idx);
        chk({tag, ".valid"}, int'(floor_valid), vld);
        chk({tag, ".changed"}, int'(floor_changed), chg);
        chk({tag, ".multi_err"}, int'(multi_err), err);
    endtask

    initial begin
        int sel;
        int hold;
        logic [NF-1:0] pat;

        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0);

        tick(20);
        expect_out("idle", 0, 0, 0, 0, 0);

        // First floor: visible DEB+2 edges after the first sampling edge.
        sensor_raw = 3'b001;
        tick(DEB + 2);
        expect_out("f1_before", 0, 0, 0, 0, 0);
        tick(1);
        expect_out("f1_arrive", 1, 1, 1, 1, 0);
        tick(1);
        expect_out("f1_pulse_end", 1, 1, 1, 0, 0);

        // Leave floor 1: display holds while between landings.
        sensor_raw = 3'b000;
        tick(10);
        expect_out("between", 1, 1, 0, 0, 0);
        sensor_raw = 3'b010;
        tick(DEB + 3);
        expect_out("f2_arrive", 2, 2, 1, 1, 0);

        // Short glitch to floor 3 is ignored.
        tick(3);
        sensor_raw = 3'b100;
        tick(DEB - 1);
        sensor_raw = 3'b010;
        tick(10);
        expect_out("glitch", 2, 2, 1, 0, 0);

        // Two sensors active: fault, floor lines hold.
        sensor_raw = 3'b110;
        tick(DEB + 3);
        expect_out("fault", 2, 2, 0, 0, 1);
        sensor_raw = 3'b100;
        tick(DEB + 3);
        expect_out("f3_recover", 4, 3, 1, 1, 0);

        // Same floor again after travelling: valid returns, no change pulse.
        sensor_raw = 3'b000;
        tick(10);
        sensor_raw = 3'b100;
        tick(DEB + 3);
        expect_out("f3_again", 4, 3, 1, 0, 0);

        // Reset just before a qualify lands: full latency afterwards.
        sensor_raw = 3'b001;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_out("mid_reset", 0, 0, 0, 0, 0);
        tick(DEB + 2);
        expect_out("post_reset_wait", 0, 0, 0, 0, 0);
        tick(1);
        expect_out("post_reset_arrive", 1, 1, 1, 1, 0);

        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) pat = 3'(1 << $urandom_range(0, NF - 1));
            else if (sel <= 7) pat = '0;
            else if (sel == 8) begin
                case ($urandom_range(0, 3))
                    0: pat = 3'b011;
                    1: pat = 3'b101;
                    2: pat = 3'b110;
                    default: pat = 3'b111;
                endcase
            end else pat = 3'($urandom_range(0, 7));
            sensor_raw = pat;
            hold = $urandom_range(1, 9);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick(hold);
        end

        tick(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floor_sensor_encoder.md
Name: floor_sensor_encoder

Overview:
Producer side of the floor-indicator interface. Turns raw, noisy, asynchronous per-floor landing sensors into clean, registered, one-hot floor lines (floor1/floor2/floor3 order) for the seven-segment display decoder. That decoder reacts to rising edges, so these outputs must be glitch-free levels that are only ever zero or one-hot. The block sits between the shaft sensors and the display/controller logic.

Parameters:
NUM_FLOORS, 3, number of landings; bit i of every floor vector is floor i+1.
DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples needed to qualify a sensor pattern (minimum 1).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter (derived; not overridden).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
sensor_raw  input  NUM_FLOORS  asynchronous landing sensors, 1 = car at that landing
floor_onehot  output  NUM_FLOORS  registered last valid floor, one-hot, or all-zero before the first valid floor
floor_index  output  2  binary floor number 1..NUM_FLOORS; 0 = none yet
floor_valid  output  1  1 while the car is qualified at a landing (state AT_FLOOR)
floor_changed  output  1  one-cycle pulse in the cycle after floor_onehot takes a new value
multi_err  output  1  1 while in FAULT

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): sync flops, stable pattern, counter, floor_onehot, floor_index, floor_valid, floor_changed and multi_err all go to 0. State goes to UNKNOWN. Reset overrides everything, including a qualification in the same cycle.
- Synchronizer: 2-flop on every sensor_raw bit. s2 is the synchronized pattern.
- Debounce:
  - If s2 differs from the held candidate, load the candidate and clear the counter to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - "Qualify" is a single-cycle event when the counter reaches DEBOUNCE_CYCLES-1 on an increment. For DEBOUNCE_CYCLES=1 it fires on every candidate load.
- Latency: let raw change at edge k be held. floor_onehot, floor_index, floor_valid and multi_err update at edge k+DEBOUNCE_CYCLES+2. floor_changed is high during the following cycle. Any raw pulse shorter than DEBOUNCE_CYCLES cycles (after sync) causes no output change.
- FSM states: UNKNOWN, AT_FLOOR, BETWEEN, FAULT. Transitions happen only on a qualify event, based on the candidate pattern:
  - One-hot: go to AT_FLOOR from any state. Load floor_onehot and floor_index. floor_changed pulses only if the value differs from the previous floor_onehot.
  - All-zero: from AT_FLOOR go to BETWEEN. UNKNOWN stays UNKNOWN. BETWEEN stays BETWEEN. FAULT stays FAULT. floor_onehot holds the last floor so the display persists between landings.
  - More than one bit set: go to FAULT from any state. multi_err=1. floor_onehot and floor_index hold.
  - FAULT is sticky until a qualified one-hot pattern arrives. No timeout.
- Outputs come straight from flops. floor_onehot never shows a non-one-hot nonzero value. It goes directly from one floor to the next in a single edge.
- floor_valid = (state == AT_FLOOR). multi_err = (state == FAULT).
- Re-qualifying the same floor after BETWEEN: floor_valid rises, and floor_changed stays 0.
- Reset mid-debounce discards the partial count. After reset, the first qualify needs the full latency.

Decomposition:
- Package elevator_pkg holds:
  - NUM_FLOORS default
  - floor_state_t enum {UNKNOWN, AT_FLOOR, BETWEEN, FAULT}
  - a onehot-to-index function shared with the display path
- Sub-module sensor_debounce: 2-flop sync, candidate register and counter. Outputs the candidate pattern and a qualify pulse. It is parameterized by width and DEBOUNCE_CYCLES.
- The top level holds the FSM and output registers.

Test Plan:
- Reset then idle, sensor_raw=000 for 20 cycles -> all outputs 0, state UNKNOWN, no floor_changed pulse.
- sensor_raw 000->001 first sampled at edge 10, held -> at edge 16: floor_onehot=001, floor_index=1, floor_valid=1; floor_changed=1 for exactly one cycle after.
- From floor 1: sensor_raw to 000 for 10 cycles, then 010 -> floor_valid drops and floor_onehot holds 001 during 000; then floor_onehot goes 001->010 at a single edge, floor_index=2, one floor_changed pulse.
- Glitch: at floor 2, sensor_raw pulses 100 for 3 cycles (DEBOUNCE_CYCLES=4) then back to 010 -> no output change, no pulse.
- Sensor_raw=110 held -> multi_err=1, floor_onehot holds the prior value; then 100 held -> multi_err=0, floor_onehot=100, floor_index=3, pulse.
- rst asserted 2 cycles before a qualify would fire -> outputs 0 after reset; the pattern requalifies only after the full DEBOUNCE_CYCLES+2 edges post-reset.
